// File: rtl/pu_riscv_pmp_gate.sv
// pu_riscv_pmp_gate: puts a single-outstanding PMP check in front of the BIU.
// Each access is captured, sent to the PMP checker for one cycle, and then
// either faulted or issued on the bus. Define PU_RISCV_PMP_GATE_MISALIGN_EN
// to enable the misaligned-address check, which takes priority over the PMP
// verdict. Completion and fault reporting use registered, one-cycle pulses.
module pu_riscv_pmp_gate #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            req_i,
  input  logic [PLEN-1:0] adr_i,
  input  logic [2:0]      size_i,
  input  logic            we_i,
  input  logic            instruction_i,
  input  logic [XLEN-1:0] d_i,
  input  logic            flush_i,
  output logic            ack_o,

  output logic            pmp_req_o,
  output logic [PLEN-1:0] pmp_adr_o,
  output logic [2:0]      pmp_size_o,
  output logic            pmp_we_o,
  output logic            pmp_instruction_o,
  input  logic            pmp_exception_i,

  output logic            biu_stb_o,
  output logic [PLEN-1:0] biu_adr_o,
  output logic [2:0]      biu_size_o,
  output logic            biu_we_o,
  output logic [XLEN-1:0] biu_d_o,
  input  logic            biu_stb_ack_i,
  input  logic            biu_ack_i,
  input  logic            biu_err_i,
  input  logic [XLEN-1:0] biu_q_i,

  output logic [XLEN-1:0] q_o,
  output logic            done_o,
  output logic            pmp_fault_o,
  output logic            misaligned_o,
  output logic            bus_err_o,
  output logic [PLEN-1:0] fault_adr_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_FAULT,
    ST_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  // holding registers for the accepted access
  logic [PLEN-1:0] r_adr;
  logic [2:0]      r_size;
  logic            r_we;
  logic            r_instruction;
  logic [XLEN-1:0] r_d;

  // result registers
  logic [XLEN-1:0] r_q;
  logic [PLEN-1:0] r_fault_adr;
  logic            r_done;
  logic            r_pmp_fault;
  logic            r_bus_err;

  // per-cycle events, decoded from the current state and inputs
  logic            w_accept;
  logic            w_done_evt;
  logic            w_pmp_fault_evt;
  logic            w_mis_evt;
  logic            w_bus_err_evt;
  logic            w_misaligned;

`ifdef PU_RISCV_PMP_GATE_MISALIGN_EN
  localparam logic [2:0] SZ_BYTE  = 3'b000;
  localparam logic [2:0] SZ_HWORD = 3'b001;
  localparam logic [2:0] SZ_WORD  = 3'b010;
  localparam logic [2:0] SZ_DWORD = 3'b011;
  localparam logic [2:0] SZ_QWORD = 3'b100;

  logic r_misaligned;

  // alignment check of the held address against the held transfer size
  always_comb begin
    w_misaligned = 1'b0;
    case (r_size)
      SZ_BYTE:  w_misaligned = 1'b0;
      SZ_HWORD: w_misaligned = r_adr[0];
      SZ_WORD:  w_misaligned = |r_adr[1:0];
      SZ_DWORD: w_misaligned = |r_adr[2:0];
      SZ_QWORD: w_misaligned = |r_adr[3:0];
      default:  w_misaligned = 1'b0;
    endcase
  end

  // misaligned fault pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_misaligned <= 1'b0;
    else       r_misaligned <= w_mis_evt;
  end

  assign misaligned_o = r_misaligned;
`else
  assign w_misaligned = 1'b0;
  assign misaligned_o = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (flush_i)                             w_next_state = ST_IDLE;
        else if (w_misaligned || pmp_exception_i) w_next_state = ST_FAULT;
        else                                     w_next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (flush_i)            w_next_state = ST_IDLE;
        else if (biu_stb_ack_i) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // a flush that coincides with the bus response has nothing left to drain
        if (biu_ack_i || biu_err_i) w_next_state = ST_IDLE;
        else if (flush_i)           w_next_state = ST_DRAIN;
      end
      ST_FAULT: begin
        w_next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        if (biu_ack_i || biu_err_i) w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // combinational outputs and event decode
  always_comb begin
    w_accept        = 1'b0;
    w_done_evt      = 1'b0;
    w_pmp_fault_evt = 1'b0;
    w_mis_evt       = 1'b0;
    w_bus_err_evt   = 1'b0;
    pmp_req_o       = 1'b0;
    biu_stb_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = req_i & ~flush_i;
      end
      ST_CHECK: begin
        pmp_req_o = 1'b1;
        if (!flush_i) begin
          if (w_misaligned)         w_mis_evt       = 1'b1;
          else if (pmp_exception_i) w_pmp_fault_evt = 1'b1;
        end
      end
      ST_ISSUE: begin
        biu_stb_o = ~flush_i;
      end
      ST_WAIT: begin
        if (!flush_i) begin
          if (biu_err_i)      w_bus_err_evt = 1'b1;
          else if (biu_ack_i) w_done_evt    = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign ack_o = w_accept;

  // capture the accepted access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_adr         <= '0;
      r_size        <= '0;
      r_we          <= 1'b0;
      r_instruction <= 1'b0;
      r_d           <= '0;
    end else if (w_accept) begin
      r_adr         <= adr_i;
      r_size        <= size_i;
      r_we          <= we_i;
      r_instruction <= instruction_i;
      r_d           <= d_i;
    end
  end

  // read data and faulting address
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q         <= '0;
      r_fault_adr <= '0;
    end else begin
      if (w_done_evt && !r_we) r_q <= biu_q_i;
      if (w_pmp_fault_evt || w_mis_evt || w_bus_err_evt) r_fault_adr <= r_adr;
    end
  end

  // completion and fault pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done      <= 1'b0;
      r_pmp_fault <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_done      <= w_done_evt;
      r_pmp_fault <= w_pmp_fault_evt;
      r_bus_err   <= w_bus_err_evt;
    end
  end

  assign pmp_adr_o         = r_adr;
  assign pmp_size_o        = r_size;
  assign pmp_we_o          = r_we;
  assign pmp_instruction_o = r_instruction;

  assign biu_adr_o  = r_adr;
  assign biu_size_o = r_size;
  assign biu_we_o   = r_we;
  assign biu_d_o    = r_d;

  assign q_o         = r_q;
  assign fault_adr_o = r_fault_adr;
  assign done_o      = r_done;
  assign pmp_fault_o = r_pmp_fault;
  assign bus_err_o   = r_bus_err;

endmodule

// File: doc/pu_riscv_pmp_gate.md
PU_RISCV_PMP_GATE -- requirements
Module: pu_riscv_pmp_gate

Interface
REQ-001 Parameter XLEN, default 64, data width.
REQ-002 Parameter PLEN, default 64, physical address width.
REQ-003 Ports SHALL be exactly as follows (name  direction  width  meaning):
- clk_i  in  1  the block's one clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  1  upstream access request.
- adr_i  in  PLEN  physical address.
- size_i  in  3  transfer size (biu package encoding: BYTE..QWORD).
- we_i  in  1  write enable.
- instruction_i  in  1  instruction fetch.
- d_i  in  XLEN  write data.
- flush_i  in  1  abandon the current access.
- ack_o  out  1  request accepted.
- pmp_req_o, pmp_adr_o, pmp_size_o, pmp_we_o, pmp_instruction_o  out  1/PLEN/3/1/1  drive the PMP checker.
- pmp_exception_i  in  1  PMP checker verdict.
- biu_stb_o  out  1  bus strobe.
- biu_adr_o, biu_size_o, biu_we_o, biu_d_o  out  PLEN/3/1/XLEN  bus request fields.
- biu_stb_ack_i  in  1  strobe accepted.
- biu_ack_i  in  1  data phase done.
- biu_err_i  in  1  bus error.
- biu_q_i  in  XLEN  read data.
- q_o  out  XLEN  read data.
- done_o  out  1  access completed.
- pmp_fault_o  out  1  PMP access fault.
- misaligned_o  out  1  misaligned fault.
- bus_err_o  out  1  bus fault.
- fault_adr_o  out  PLEN  faulting address.

Function
REQ-004 FSM states SHALL be IDLE, CHECK, ISSUE, WAIT, FAULT, DRAIN.
REQ-005 IDLE: ack_o SHALL equal req_i (combinational). On req_i the block SHALL capture adr/size/we/instruction/d into holding registers and go to CHECK.
REQ-006 pmp_req_o SHALL be 1 only in CHECK. The pmp_* fields SHALL always equal the holding registers.
REQ-007 CHECK (exactly one cycle): if pmp_exception_i=1 the block SHALL go to FAULT, setting fault_adr_o=held adr. Otherwise it SHALL go to ISSUE.
REQ-008 ISSUE: biu_stb_o=1 with the held fields, stable until biu_stb_ack_i. On biu_stb_ack_i the block SHALL go to WAIT.
REQ-009 WAIT: on biu_ack_i, q_o<=biu_q_i (reads only; unchanged on writes), done_o pulses 1 cycle, next state IDLE.
REQ-010 WAIT: on biu_err_i, bus_err_o pulses 1 cycle, fault_adr_o<=held adr, next state IDLE. biu_err_i has priority over a simultaneous biu_ack_i.
REQ-011 FAULT: pmp_fault_o=1 for exactly one cycle, then IDLE. No biu_stb_o SHALL ever be issued for a faulting access.
REQ-012 done_o, pmp_fault_o, misaligned_o and bus_err_o SHALL be registered, mutually exclusive, one-cycle pulses.
REQ-013 Minimum latency: accept in cycle 0, check in cycle 1, biu_stb_o in cycle 2, fault pulse in cycle 2.
REQ-014 Throughput: at most one access outstanding. ack_o=0 outside IDLE.
REQ-015 flush_i in CHECK or ISSUE SHALL return to IDLE next cycle with no pulse; biu_stb_o drops the same cycle.
REQ-016 flush_i in WAIT SHALL go to DRAIN; DRAIN waits for biu_ack_i or biu_err_i, then IDLE with no pulse and q_o unchanged.
REQ-017 flush_i in IDLE SHALL block acceptance that cycle (ack_o=0).

Reset
REQ-018 rst_i SHALL asynchronously force state IDLE and set every output register to 0 (q_o, fault_adr_o, all pulses), clearing the holding registers.
REQ-019 Reset asserted mid-access SHALL abandon the access; no pulse SHALL follow release.

Configuration
REQ-020 Macro PU_RISCV_PMP_GATE_MISALIGN_EN.
- Defined: in CHECK, an adr not aligned to the size (adr mod bytes != 0) SHALL take priority over the PMP check. It SHALL pulse misaligned_o one cycle later with fault_adr_o set, and no bus strobe is issued.
- Undefined: misaligned_o is tied 0 and misaligned accesses proceed normally.

Verification
REQ-021 Read, WORD at 0x1000, pmp_exception_i=0, biu_stb_ack_i in cycle 2, biu_ack_i in cycle 4 with q=0xDEADBEEF -> done_o in cycle 5 and q_o=0xDEADBEEF.
REQ-022 Write at 0x2000, pmp_exception_i=1 -> pmp_fault_o in cycle 2, fault_adr_o=0x2000, biu_stb_o never asserted.
REQ-023 biu_err_i together with biu_ack_i in WAIT for adr 0x3008 -> bus_err_o=1, done_o=0, fault_adr_o=0x3008.
REQ-024 flush_i in WAIT, biu_ack_i 3 cycles later -> no done_o, ack_o=0 until the cycle after biu_ack_i.
REQ-025 With the macro defined, WORD at 0x1002 -> misaligned_o in cycle 2 and no biu_stb_o. Undefined -> biu_stb_o with adr 0x1002.
REQ-026 rst_i asserted while in ISSUE -> biu_stb_o=0 immediately, all outputs 0, next req_i accepted normally.
